// File: rtl/add16_mp_pkg.sv
// rtl/add16_mp_pkg.sv - shared word width and FSM encoding for the multi-precision add sequencer
package add16_mp_pkg;

  localparam int WORD_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/add16.sv
// rtl/add16.sv - 16-bit adder with carry in and carry out
module add16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] Sum,
  output logic        Cout
);

  // One 17-bit add gives both the word sum and its carry out
  always_comb begin
    {Cout, Sum} = {1'b0, A} + {1'b0, B} + {16'b0, Cin};
  end

endmodule

// File: rtl/add16_mp_seq.sv
// rtl/add16_mp_seq.sv - word-serial WORDS*16-bit adder over one add16; optional subtract via ADD16_MP_SUB_EN
module add16_mp_seq
  import add16_mp_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORDS*WORD_W-1:0] A,
  input  logic [WORDS*WORD_W-1:0] B,
  input  logic                    Cin,
  input  logic                    op_sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORDS*WORD_W-1:0] Sum,
  output logic                    Cout,
  output logic                    Ovf,
  output logic                    busy
);

  localparam int W  = WORDS * WORD_W;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_t state_q, state_d;

  logic [W-1:0]      a_q, b_q, sum_q;
  logic [IW-1:0]     idx_q;
  logic              carry_q;
  logic              cout_q, ovf_q;

  logic [W-1:0]      b_eff;
  logic              cin_eff;
  logic              accept;
  logic              last_word;

  logic [WORD_W-1:0] word_a, word_b, word_s;
  logic              word_c;

`ifdef ADD16_MP_SUB_EN
  // Subtract is A + ~B + 1; Cout then reads as "no borrow"
  always_comb begin
    b_eff   = op_sub ? ~B : B;
    cin_eff = op_sub ? 1'b1 : Cin;
  end
`else
  logic unused_op_sub;
  assign unused_op_sub = op_sub;

  // Add-only build: operands pass straight through
  always_comb begin
    b_eff   = B;
    cin_eff = Cin;
  end
`endif

  // Select the current word of each latched operand for the shared adder
  always_comb begin
    word_a = a_q[idx_q*WORD_W +: WORD_W];
    word_b = b_q[idx_q*WORD_W +: WORD_W];
  end

  add16 u_add16 (
    .A    (word_a),
    .B    (word_b),
    .Cin  (carry_q),
    .Sum  (word_s),
    .Cout (word_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    last_word = (idx_q == LAST_IDX);
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_d = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_word) state_d = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, carry ripple and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= A;
      b_q     <= b_eff;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= cin_eff;
    end else if (state_q == S_RUN) begin
      sum_q[idx_q*WORD_W +: WORD_W] <= word_s;
      carry_q <= word_c;
      if (last_word) begin
        idx_q  <= '0;
        cout_q <= word_c;
        ovf_q  <= (a_q[W-1] == b_q[W-1]) && (word_s[WORD_W-1] != a_q[W-1]);
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_add16_mp_seq.sv
// tb/tb_add16_mp_seq.sv - directed self-checking bench for add16_mp_seq with WORDS=4
module tb_add16_mp_seq;

  localparam int WORDS = 4;
  localparam int W     = 64;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A, B;
  logic         Cin;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;

  add16_mp_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operand pair at a negedge, then count cycles until out_valid
  task automatic start_and_wait(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic sub, output int lat);
    A = a; B = b; Cin = cin; op_sub = sub; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    A = '1; B = '1; Cin = 1'b0; op_sub = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: out_valid=%b busy=%b in_ready=%b, want 0 0 1", out_valid, busy, in_ready);
    end
    checks++;
    if (Sum !== 64'h0 || Cout !== 1'b0 || Ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_result: Sum=%h Cout=%b Ovf=%b, want 0 0 0", Sum, Cout, Ovf);
    end
  endtask

  task automatic test_abort();
    bit seen;
    A = 64'h1234_5678_9ABC_DEF0; B = 64'h1111_1111_1111_1111; Cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || Sum !== 64'h0) begin
      errors++;
      $display("FAIL abort_state: out_valid=%b busy=%b in_ready=%b Sum=%h, want 0 0 1 0", out_valid, busy, in_ready, Sum);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_complete: activity seen=%b, want 0", seen);
    end
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    start_and_wait(64'h1, 64'h2, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles, want 5", lat);
    end
    checks++;
    if (Sum !== 64'h3 || Cout !== 1'b0 || Ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: Sum=%h Cout=%b Ovf=%b, want 3 0 0", Sum, Cout, Ovf);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_handshake: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_ripple();
    int lat;
    out_ready = 1'b1;
    start_and_wait(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 5 || Sum !== 64'h0000_0000_0001_0000 || Cout !== 1'b0) begin
      errors++;
      $display("FAIL ripple: lat=%0d Sum=%h Cout=%b, want 5 0000000000010000 0", lat, Sum, Cout);
    end
    @(negedge clk);
  endtask

  task automatic test_all_ones();
    int lat;
    out_ready = 1'b1;
    start_and_wait(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, lat);
    checks++;
    if (Sum !== 64'hFFFF_FFFF_FFFF_FFFF || Cout !== 1'b1 || Ovf !== 1'b0) begin
      errors++;
      $display("FAIL all_ones: Sum=%h Cout=%b Ovf=%b, want ffffffffffffffff 1 0", Sum, Cout, Ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow_hold();
    int lat;
    bit unstable, ready_seen;
    out_ready = 1'b0;
    start_and_wait(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, lat);
    checks++;
    if (Sum !== 64'h8000_0000_0000_0000 || Ovf !== 1'b1 || Cout !== 1'b0) begin
      errors++;
      $display("FAIL overflow: Sum=%h Ovf=%b Cout=%b, want 8000000000000000 1 0", Sum, Ovf, Cout);
    end
    unstable = 1'b0;
    ready_seen = 1'b0;
    A = 64'h5; B = 64'h5; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || Sum !== 64'h8000_0000_0000_0000 || Ovf !== 1'b1 || Cout !== 1'b0) unstable = 1'b1;
      if (in_ready !== 1'b0) ready_seen = 1'b1;
    end
    in_valid = 1'b0;
    checks++;
    if (unstable !== 1'b0) begin
      errors++;
      $display("FAIL hold_stable: result changed while stalled, got %b want 0", unstable);
    end
    checks++;
    if (ready_seen !== 1'b0) begin
      errors++;
      $display("FAIL hold_in_ready: in_ready high in DONE, got %b want 0", ready_seen);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || Sum !== 64'h8000_0000_0000_0000) begin
      errors++;
      $display("FAIL ignored_in_valid: busy=%b Sum=%h, want 0 8000000000000000", busy, Sum);
    end
  endtask

  task automatic test_sub();
    int lat;
    out_ready = 1'b1;
`ifdef ADD16_MP_SUB_EN
    start_and_wait(64'h5, 64'h7, 1'b0, 1'b1, lat);
    checks++;
    if (Sum !== 64'hFFFF_FFFF_FFFF_FFFE || Cout !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow: Sum=%h Cout=%b, want fffffffffffffffe 0", Sum, Cout);
    end
    @(negedge clk);
    start_and_wait(64'h7, 64'h5, 1'b0, 1'b1, lat);
    checks++;
    if (Sum !== 64'h2 || Cout !== 1'b1) begin
      errors++;
      $display("FAIL sub_no_borrow: Sum=%h Cout=%b, want 2 1", Sum, Cout);
    end
`else
    start_and_wait(64'h5, 64'h7, 1'b0, 1'b1, lat);
    checks++;
    if (Sum !== 64'hC || Cout !== 1'b0) begin
      errors++;
      $display("FAIL op_sub_ignored: Sum=%h Cout=%b, want c 0", Sum, Cout);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    start_and_wait(64'h0001_0002_0003_0004, 64'h1000_2000_3000_4000, 1'b1, 1'b0, lat);
    checks++;
    if (lat !== 5 || Sum !== 64'h1001_2002_3003_4005) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d Sum=%h, want 5 1001200230034005", lat, Sum);
    end
    @(negedge clk);
    start_and_wait(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 5 || Sum !== 64'h0 || Cout !== 1'b1 || Ovf !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d Sum=%h Cout=%b Ovf=%b, want 5 0 1 1", lat, Sum, Cout, Ovf);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0; op_sub = 1'b0;
    @(negedge clk);
    test_reset();
    test_abort();
    test_basic();
    test_ripple();
    test_all_ones();
    test_overflow_hold();
    test_sub();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
